// File: rtl/spart_tx_frame.sv
// Purpose: SPART transmit framer that turns DATA_W-bit words into start/data/[parity]/stop frames, sent LSB first.
// Latency: starting from IDLE, the start bit goes out on the first baud_en after tbr drops. Frames follow each other with no idle gap.
// Backpressure: tbr=0 means the holding register is full. A write made while it is full is dropped and sets the sticky ovr flag.
// Build option: define SPART_TX_PARITY_EN to include the PARITY state and honour parity_mode.
module spart_tx_frame #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_en,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        parity_mode,
  input  logic              ovr_clr,
  output logic              out,
  output logic              tbr,
  output logic              busy,
  output logic              ovr
);

  localparam int CNT_W = $clog2(DATA_W + 4);

`ifdef SPART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic               tbr_q, tbr_d;
  logic               out_q, out_d;
  logic               busy_q, busy_d;
  logic               ovr_q, ovr_d;
  logic               last_stop;
  logic               xfer;
  logic               overrun;
`ifdef SPART_TX_PARITY_EN
  logic               par_en_q, par_en_d;
  logic               par_bit_q, par_bit_d;
`else
  // parity_mode has no function in this build; the port is kept so both builds share one interface
  logic               unused_parity;
  assign unused_parity = ^parity_mode;
`endif

  // The last stop bit finishes on this tick; a pending word can then follow with no idle gap
  assign last_stop = (state_q == S_STOP) && (cnt_q == CNT_W'(STOP_BITS - 1));
  assign xfer      = baud_en && !tbr_q && ((state_q == S_IDLE) || last_stop);
  assign overrun   = wr_en && !tbr_q && !xfer;

  // Next-state logic for the holding register, the overrun flag and the line FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    tbr_d   = tbr_q;
    out_d   = out_q;
    ovr_d   = ovr_q;
`ifdef SPART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif

    // A write in the same cycle as a transfer refills the holding register immediately
    if (wr_en && (tbr_q || xfer)) begin
      hold_d = data;
      tbr_d  = 1'b0;
    end else if (xfer) begin
      tbr_d  = 1'b1;
    end

    // If an overrun and a clear arrive together, the set takes priority
    if (overrun)      ovr_d = 1'b1;
    else if (ovr_clr) ovr_d = 1'b0;

    if (baud_en) begin
      case (state_q)
        S_IDLE: begin
          // With no pending word, a tick has no effect here
        end
        S_START: begin
          out_d   = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = CNT_W'(1);
          state_d = S_DATA;
        end
        S_DATA: begin
          if (cnt_q == CNT_W'(DATA_W)) begin
`ifdef SPART_TX_PARITY_EN
            if (par_en_q) begin
              out_d   = par_bit_q;
              state_d = S_PARITY;
            end else begin
              out_d   = 1'b1;
              cnt_d   = '0;
              state_d = S_STOP;
            end
`else
            out_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_STOP;
`endif
          end else begin
            out_d   = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
`ifdef SPART_TX_PARITY_EN
        S_PARITY: begin
          out_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_STOP;
        end
`endif
        S_STOP: begin
          if (last_stop) begin
            out_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            out_d   = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          out_d   = 1'b1;
          state_d = S_IDLE;
        end
      endcase

      // A transfer loads the shifter and drives the start bit, from IDLE or from the last stop bit
      if (xfer) begin
        shift_d = hold_q;
        cnt_d   = '0;
        out_d   = 1'b0;
        state_d = S_START;
`ifdef SPART_TX_PARITY_EN
        par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_bit_d = (^hold_q) ^ parity_mode[1];
`endif
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // State registers, with a synchronous reset that aborts any frame in progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      tbr_q   <= 1'b1;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SPART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      tbr_q   <= tbr_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
`ifdef SPART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  assign out  = out_q;
  assign tbr  = tbr_q;
  assign busy = busy_q;
  assign ovr  = ovr_q;

endmodule

// File: tb/tb_spart_tx_frame.sv
// Bench for spart_tx_frame. It drives two instances, (DATA_W=8, STOP=1) and (DATA_W=7, STOP=2), with shared stimulus.
// A queue holds the expected line bits in order and is compared once per baud tick.
// Define SPART_TX_PARITY_EN to cover the parity build.
module tb_spart_tx_frame;

  logic       clk = 1'b0;
  logic       rst_n, baud_en, wr_en, ovr_clr;
  logic [7:0] data;
  logic [1:0] parity_mode;
  logic       out_a, tbr_a, busy_a, ovr_a;
  logic       out_b, tbr_b, busy_b, ovr_b;
  logic       out_s, tbr_s, busy_s, ovr_s;
  int         cfg = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  logic       exp_q[$];

  always #5 clk = ~clk;

  spart_tx_frame #(.DATA_W(8), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .baud_en(baud_en), .wr_en(wr_en), .data(data),
    .parity_mode(parity_mode), .ovr_clr(ovr_clr),
    .out(out_a), .tbr(tbr_a), .busy(busy_a), .ovr(ovr_a));

  spart_tx_frame #(.DATA_W(7), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .baud_en(baud_en), .wr_en(wr_en), .data(data[6:0]),
    .parity_mode(parity_mode), .ovr_clr(ovr_clr),
    .out(out_b), .tbr(tbr_b), .busy(busy_b), .ovr(ovr_b));

  assign out_s  = (cfg == 1) ? out_b  : out_a;
  assign tbr_s  = (cfg == 1) ? tbr_b  : tbr_a;
  assign busy_s = (cfg == 1) ? busy_b : busy_a;
  assign ovr_s  = (cfg == 1) ? ovr_b  : ovr_a;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected line bits for one frame of the selected configuration
  task automatic push_frame(input logic [7:0] d, input logic [1:0] pm);
    int dw = (cfg == 1) ? 7 : 8;
    int sb = (cfg == 1) ? 2 : 1;
    logic p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      exp_q.push_back(d[i]);
      p = p ^ d[i];
    end
`ifdef SPART_TX_PARITY_EN
    if (pm == 2'b01) exp_q.push_back(p);
    if (pm == 2'b10) exp_q.push_back(~p);
`endif
    for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
  endtask

  // One baud tick. The line bit is then checked against the scoreboard, or against idle high if the scoreboard is empty.
  task automatic tick_chk(input bit do_wr = 1'b0, input logic [7:0] d = 8'h00);
    logic e;
    baud_en = 1'b1;
    if (do_wr) begin
      wr_en = 1'b1;
      data  = d;
    end
    @(negedge clk);
    baud_en = 1'b0;
    wr_en   = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
    check("line", out_s, e);
    if (do_wr) push_frame(d, parity_mode);
  endtask

  task automatic wr(input logic [7:0] d, input logic [1:0] pm, input bit accept, input bit clr = 1'b0);
    wr_en       = 1'b1;
    data        = d;
    parity_mode = pm;
    ovr_clr     = clr;
    @(negedge clk);
    wr_en   = 1'b0;
    ovr_clr = 1'b0;
    if (accept) push_frame(d, pm);
  endtask

  // Send out every queued bit, then check that the line returns to idle
  task automatic drain();
    int g = 0;
    while (exp_q.size() > 0 && g < 200) begin
      tick_chk();
      g++;
    end
    check("busy_last_stop", busy_s, 1'b1);
    tick_chk();
    check("busy_idle", busy_s, 1'b0);
    check("tbr_idle", tbr_s, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    check("rst_out", out_s, 1'b1);
    check("rst_tbr", tbr_s, 1'b1);
    check("rst_busy", busy_s, 1'b0);
    check("rst_ovr", ovr_s, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; baud_en = 1'b0; wr_en = 1'b0; ovr_clr = 1'b0;
    data = 8'h00; parity_mode = 2'b00;
    repeat (3) @(negedge clk);

    // Reset and idle ticks: no activity
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick_chk();
      check("idle_tbr", tbr_s, 1'b1);
      check("idle_busy", busy_s, 1'b0);
      check("idle_ovr", ovr_s, 1'b0);
    end

    // 0xA5 without parity
    wr(8'hA5, 2'b00, 1'b1);
    check("tbr_after_wr", tbr_s, 1'b0);
    tick_chk();
    check("tbr_after_xfer", tbr_s, 1'b1);
    check("busy_after_xfer", busy_s, 1'b1);
    drain();

    // Parity modes. In the default build parity_mode is ignored
    wr(8'hA5, 2'b01, 1'b1);
    drain();
    wr(8'hA5, 2'b10, 1'b1);
    drain();
    wr(8'hA5, 2'b11, 1'b1);
    drain();
    parity_mode = 2'b00;

    // Back-to-back frames with no idle bit between them
    wr(8'h11, 2'b00, 1'b1);
    tick_chk();
    wr(8'h22, 2'b00, 1'b1);
    check("b2b_tbr", tbr_s, 1'b0);
    drain();

    // Overrun: a dropped write, priority of set over clear, then a clear
    wr(8'h11, 2'b00, 1'b1);
    tick_chk();
    wr(8'h22, 2'b00, 1'b1);
    check("pre_ovr", ovr_s, 1'b0);
    wr(8'h33, 2'b00, 1'b0);
    check("ovr_set", ovr_s, 1'b1);
    check("ovr_tbr", tbr_s, 1'b0);
    wr(8'h44, 2'b00, 1'b0, 1'b1);
    check("ovr_set_wins", ovr_s, 1'b1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_clr", ovr_s, 1'b0);
    // Finish the 0x11 frame. The next tick transfers 0x22, and 0x55 is written in that same cycle
    for (int i = 0; i < 9; i++) tick_chk();
    tick_chk(1'b1, 8'h55);
    check("xfer_wr_tbr", tbr_s, 1'b0);
    check("xfer_wr_ovr", ovr_s, 1'b0);
    drain();
    check("ovr_stays_clr", ovr_s, 1'b0);

    // Reset in the middle of a frame, then a clean frame
    wr(8'h5A, 2'b00, 1'b1);
    repeat (4) tick_chk();
    do_reset();
    wr(8'h5A, 2'b00, 1'b1);
    drain();

    // The same sequence on the 7-bit, 2-stop-bit instance
    cfg = 1;
    do_reset();
    wr(8'h5A, 2'b00, 1'b1);
    repeat (4) tick_chk();
    do_reset();
    wr(8'h5A, 2'b00, 1'b1);
    drain();
    wr(8'h3C, 2'b00, 1'b1);
    tick_chk();
    wr(8'h41, 2'b00, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
